node_port_adapter: RTL

- Link-side adapter between the x-port ring/mesh links and one routing node: port remapping around the node's own index g, per-port ingress FIFOs with ready/valid backpressure, registered egress with backpressure, loopback sentinel filtering and an alignment-gated run state machine.
- Replaces fixed-depth, non-backpressured wrapping.
- Node core and controller attach on the node side; link port 0 is always the controller channel.

---
 rtl/node_port_adapter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/node_port_adapter.sv
// Link-side adapter for one routing node: link/node port remapping around the node index g,
// per-port ingress FIFOs, registered egress slices, loopback sentinel filter and alignment-gated run FSM.
module node_port_adapter #(
  parameter int x          = 3,
  parameter int g          = 0,
  parameter int w          = 128,
  parameter int D          = 8,
  parameter int ALIGN_HOLD = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [x-1:0]       aligned,
  input  logic [w*x-1:0]     idata,
  input  logic [x-1:0]       ivalid,
  output logic [x-1:0]       iready,
  output logic [w*x-1:0]     odata,
  output logic [x-1:0]       ovalid,
  input  logic [x-1:0]       oready,
  output logic [w*x-1:0]     nd_idata,
  output logic [x-1:0]       nd_ivalid,
  input  logic [x-1:0]       nd_iready,
  input  logic [w*x-1:0]     nd_odata,
  input  logic [x-1:0]       nd_ovalid,
  output logic [x-1:0]       nd_oready,
  output logic               node_rst_n,
  output logic               running,
  output logic [CNT_W-1:0]   ovf_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int AW = $clog2(D);
  localparam int HW = $clog2(ALIGN_HOLD + 1);

  typedef enum logic [1:0] {WAIT_ALIGN = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          all_aligned, run, drop;
  logic [x-1:0]  full, empty, push, pop;
  logic          unused_link0;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign all_aligned  = &aligned;
  assign run          = (state == RUN);
  assign running      = run;
  // HALT is only reachable from RUN, so leaving WAIT_ALIGN means the node was released.
  assign node_rst_n   = (state != WAIT_ALIGN);
  assign unused_link0 = ^{oready[0], idata[w-1:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= WAIT_ALIGN;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = '0;
    case (state)
      WAIT_ALIGN, HALT: begin
        if (all_aligned) begin
          if (hold_cnt == HW'(ALIGN_HOLD)) state_nxt = RUN;
          else                             hold_nxt  = hold_cnt + HW'(1);
        end
      end
      RUN:     if (!all_aligned) state_nxt = HALT;
      default: state_nxt = WAIT_ALIGN;
    endcase
  end

  // Ingress FIFO per node port; port g is fed from the node's own egress (loopback).
  for (genvar p = 0; p < x; p++) begin : g_fifo
    logic [w-1:0]  mem [D];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic [w-1:0]  din;

    assign full[p]  = (cnt == (AW+1)'(D));
    assign empty[p] = (cnt == '0);

    if (p == g) begin : g_lb
      assign din          = nd_odata[w*p +: w];
      assign nd_oready[p] = run && !full[p];
      assign push[p]      = nd_ovalid[p] && nd_oready[p] && (din != '1);
    end else begin : g_ln
      localparam int L = (p < g) ? p + 1 : p;
      assign din     = idata[w*L +: w];
      assign push[p] = ivalid[L] && iready[L];
    end

    assign nd_ivalid[p]        = run && !empty[p];
    assign pop[p]              = nd_ivalid[p] && nd_iready[p];
    assign nd_idata[w*p +: w]  = nd_ivalid[p] ? mem[rptr] : '0;

    always_ff @(posedge clock) begin
      if (push[p]) mem[wptr] <= din;
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (push[p]) wptr <= wptr + AW'(1);
        if (pop[p])  rptr <= rptr + AW'(1);
        case ({push[p], pop[p]})
          2'b10:   cnt <= cnt + (AW+1)'(1);
          2'b01:   cnt <= cnt - (AW+1)'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Link side: link 0 is the reserved controller channel, the rest map onto node ports.
  for (genvar l = 0; l < x; l++) begin : g_link
    if (l == 0) begin : g_ctrl
      assign iready[l]          = 1'b0;
      assign ovalid[l]          = 1'b0;
      assign odata[w*l +: w]    = '0;
    end else begin : g_port
      localparam int N = (l <= g) ? l - 1 : l;
      logic [w-1:0] odata_p1;
      logic         vld_p1;
      logic         load;

      assign iready[l]       = run && !full[N];
      assign nd_oready[N]    = run && (!vld_p1 || oready[l]);
      assign load            = nd_ovalid[N] && nd_oready[N];
      assign ovalid[l]       = vld_p1;
      assign odata[w*l +: w] = odata_p1;

      // ---- egress stage p1: node word registered toward the link ----
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          vld_p1   <= 1'b0;
          odata_p1 <= '0;
        end else if (load) begin
          vld_p1   <= 1'b1;
          odata_p1 <= nd_odata[w*N +: w];
        end else if (oready[l]) begin
          vld_p1   <= 1'b0;
        end
      end
    end
  end

  assign drop = nd_ovalid[g] && nd_oready[g] && (nd_odata[w*g +: w] == '1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      ovf_cnt <= sat_add(ovf_cnt, CNT_W'($countones(ivalid & ~iready)));
      if (drop) drop_cnt <= sat_add(drop_cnt, CNT_W'(1));
    end
  end

endmodule
